bsg_wormhole_router_adapter_out: RTL

Receive-side adapter for the wormhole router. It accepts a stream of flits from a router output port over a ready/and link and reassembles them into one wide packet of the form {payload, length, cord}. The length field in the header flit sets the flit count. The assembled packet is presented on a valid/yumi interface to the endpoint. It is the receiver counterpart of the router input adapter, and the packet layout and flit ordering match it bit for bit.

---
 rtl/bsg_wormhole_router_adapter_out.sv | 109 ++++++++++
 1 files changed

// File: rtl/bsg_wormhole_router_adapter_out.sv
// Receive-side wormhole adapter: collects header + body flits from a router
// output port and presents the reassembled {payload, len, cord} packet on valid/yumi.
module bsg_wormhole_router_adapter_out #(
  parameter int max_payload_width_p = 20,
  parameter int len_width_p         = 2,
  parameter int cord_width_p        = 4,
  parameter int flit_width_p        = 8
) (
  input  logic                                                     clk_i,
  input  logic                                                     reset_n_i,
  input  logic [flit_width_p+1:0]                                  link_i,
  output logic [flit_width_p+1:0]                                  link_o,
  output logic [cord_width_p+len_width_p+max_payload_width_p-1:0]  packet_o,
  output logic                                                     v_o,
  input  logic                                                     yumi_i
);

  localparam int P = cord_width_p + len_width_p + max_payload_width_p;
  localparam int N = (P + flit_width_p - 1) / flit_width_p;
  localparam int B = N * flit_width_p;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [B-1:0]              r_buf;
  logic [len_width_p-1:0]    r_len;
  logic [len_width_p-1:0]    r_count;

  logic                      w_link_v;
  logic [flit_width_p-1:0]   w_flit;
  logic [len_width_p-1:0]    w_hdr_len;
  logic                      w_ready;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_unused_link_rdy;

  assign w_link_v          = link_i[flit_width_p+1];
  assign w_flit            = link_i[flit_width_p:1];
  assign w_unused_link_rdy = link_i[0];
  assign w_hdr_len         = w_flit[cord_width_p +: len_width_p];
  assign w_accept          = w_link_v & w_ready;
  assign w_last            = (r_count == r_len);

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = (w_hdr_len == '0) ? ST_DONE : ST_BODY;
      ST_BODY: if (w_accept && w_last) w_state_nxt = ST_DONE;
      ST_DONE: if (yumi_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs; ready is gated by reset so nothing is taken while held in reset
  always_comb begin
    w_ready = reset_n_i & (r_state != ST_DONE);
    v_o     = (r_state == ST_DONE);
  end

  // Datapath: header clears the whole buffer so short packets leave upper slots zero
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_buf   <= '0;
      r_len   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      if (r_state == ST_IDLE) begin
        r_buf                   <= '0;
        r_buf[flit_width_p-1:0] <= w_flit;
        r_len                   <= w_hdr_len;
        r_count                 <= len_width_p'(1);
      end else if (r_state == ST_BODY) begin
        // Slots past N are silently dropped for an oversized len
        for (int unsigned i = 0; i < N; i++) begin
          if (32'(r_count) == i) r_buf[i*flit_width_p +: flit_width_p] <= w_flit;
        end
        if (!w_last) r_count <= r_count + 1'b1;
      end
    end
  end

  assign packet_o = r_buf[P-1:0];
  assign link_o   = {1'b0, {flit_width_p{1'b0}}, w_ready};

  generate
    if (B > P) begin : g_pad
      logic w_unused_pad;
      assign w_unused_pad = ^r_buf[B-1:P];
    end
  endgenerate

  hdr_len_in_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (r_state == ST_IDLE && w_accept) |-> (int'(w_hdr_len) < N))
    else $error("bsg_wormhole_router_adapter_out: header len %0d exceeds %0d slots",
                w_hdr_len, N);

endmodule
